// File: rtl/i2c_pkg.sv
// Shared I2C defaults used by the slave PHY and the word buffer.
// I2C_DW is the PHY word width, I2C_AW the buffer address width.
package i2c_pkg;

    localparam int I2C_DW = 32;
    localparam int I2C_AW = 4;

endpackage

// File: rtl/i2c_buf_fifo.sv
// First-word-fall-through FIFO with occupancy count and sticky error flags.
// Ports: clk, rst_n, flush; wr/wdata in, rd in, rdata head out;
// full, empty, cnt status; ovf (write while full), udf (read while empty).
module i2c_buf_fifo
    import i2c_pkg::*;
#(
    parameter int AW = I2C_AW,
    parameter int DW = I2C_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   cnt,
    output logic          ovf,
    output logic          udf
);

    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_acc;
    logic          rd_acc;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);

    // Acceptance looks only at the registered state, so a read in the
    // same cycle never makes room for a write to a full FIFO.
    assign wr_acc = wr && !full && !flush;
    assign rd_acc = rd && !empty && !flush;

    // Head is a plain combinational read: valid as soon as cnt != 0.
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
            if (wr && full) begin
                ovf <= 1'b1;
            end
            if (rd && empty) begin
                udf <= 1'b1;
            end
        end
    end

    // Storage is only ever read below cnt, so it carries no reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/i2c_buf.sv
// Word buffer between the I2C slave PHY and the host register interface.
// RX: phy_push/phy_dout/phy_full in, host rx_rd/rx_data/rx_empty/rx_cnt/rx_ovf.
// TX: host tx_wr/tx_data/tx_full/tx_cnt in, phy_pop/phy_din/phy_empty/tx_udf.
module i2c_buf
    import i2c_pkg::*;
#(
    parameter int AW = I2C_AW,
    parameter int DW = I2C_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          phy_push,
    input  logic [DW-1:0] phy_dout,
    output logic          phy_full,
    input  logic          phy_pop,
    output logic [DW-1:0] phy_din,
    output logic          phy_empty,
    input  logic          rx_rd,
    output logic [DW-1:0] rx_data,
    output logic          rx_empty,
    output logic [AW:0]   rx_cnt,
    input  logic          tx_wr,
    input  logic [DW-1:0] tx_data,
    output logic          tx_full,
    output logic [AW:0]   tx_cnt,
    output logic          rx_ovf,
    output logic          tx_udf
);

    // RX never reports underflow and TX never reports overflow.
    logic unused_rx_udf;
    logic unused_tx_ovf;

    i2c_buf_fifo #(
        .AW(AW),
        .DW(DW)
    ) u_rx (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .wr   (phy_push),
        .wdata(phy_dout),
        .rd   (rx_rd),
        .rdata(rx_data),
        .full (phy_full),
        .empty(rx_empty),
        .cnt  (rx_cnt),
        .ovf  (rx_ovf),
        .udf  (unused_rx_udf)
    );

    i2c_buf_fifo #(
        .AW(AW),
        .DW(DW)
    ) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(flush),
        .wr   (tx_wr),
        .wdata(tx_data),
        .rd   (phy_pop),
        .rdata(phy_din),
        .full (tx_full),
        .empty(phy_empty),
        .cnt  (tx_cnt),
        .ovf  (unused_tx_ovf),
        .udf  (tx_udf)
    );

endmodule

// File: tb/tb_i2c_buf.sv
// Self-checking bench for i2c_buf using queue-based RX/TX models.
// Heads are compared against the model queues when a read/pop is driven.
module tb_i2c_buf;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          phy_push;
    logic [DW-1:0] phy_dout;
    logic          phy_full;
    logic          phy_pop;
    logic [DW-1:0] phy_din;
    logic          phy_empty;
    logic          rx_rd;
    logic [DW-1:0] rx_data;
    logic          rx_empty;
    logic [AW:0]   rx_cnt;
    logic          tx_wr;
    logic [DW-1:0] tx_data;
    logic          tx_full;
    logic [AW:0]   tx_cnt;
    logic          rx_ovf;
    logic          tx_udf;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rx_m[$];
    logic [31:0] tx_m[$];
    bit          ovf_m;
    bit          udf_m;

    always #5 clk = ~clk;

    i2c_buf #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .phy_push (phy_push),
        .phy_dout (phy_dout),
        .phy_full (phy_full),
        .phy_pop  (phy_pop),
        .phy_din  (phy_din),
        .phy_empty(phy_empty),
        .rx_rd    (rx_rd),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_cnt   (rx_cnt),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .tx_full  (tx_full),
        .tx_cnt   (tx_cnt),
        .rx_ovf   (rx_ovf),
        .tx_udf   (tx_udf)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic check_state();
        chk("rx_cnt", 32'(rx_cnt), 32'(rx_m.size()));
        chk("tx_cnt", 32'(tx_cnt), 32'(tx_m.size()));
        chk("rx_empty", 32'(rx_empty), 32'(rx_m.size() == 0));
        chk("phy_full", 32'(phy_full), 32'(rx_m.size() == DEPTH));
        chk("phy_empty", 32'(phy_empty), 32'(tx_m.size() == 0));
        chk("tx_full", 32'(tx_full), 32'(tx_m.size() == DEPTH));
        chk("rx_ovf", 32'(rx_ovf), 32'(ovf_m));
        chk("tx_udf", 32'(tx_udf), 32'(udf_m));
        if (rx_m.size() > 0) chk("rx_data_vis", rx_data, rx_m[0]);
        if (tx_m.size() > 0) chk("phy_din_vis", phy_din, tx_m[0]);
    endtask

    // Drive one cycle of strobes at the falling edge, update the model,
    // clock it, then check all observable state at the next falling edge.
    task automatic cycle(input bit push, input logic [31:0] pd,
                         input bit pop, input bit rd, input bit wr,
                         input logic [31:0] wd, input bit fl);
        int rs;
        int ts;
        phy_push = push;
        phy_dout = pd;
        phy_pop  = pop;
        rx_rd    = rd;
        tx_wr    = wr;
        tx_data  = wd;
        flush    = fl;
        #1;
        rs = rx_m.size();
        ts = tx_m.size();
        if (!fl) begin
            if (rd && rs > 0) chk("rx_head", rx_data, rx_m[0]);
            if (pop && ts > 0) chk("phy_head", phy_din, tx_m[0]);
        end
        if (fl) begin
            rx_m.delete();
            tx_m.delete();
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end else begin
            if (push) begin
                if (rs < DEPTH) rx_m.push_back(pd);
                else ovf_m = 1'b1;
            end
            if (rd && rs > 0) void'(rx_m.pop_front());
            if (wr && ts < DEPTH) tx_m.push_back(wd);
            if (pop) begin
                if (ts > 0) void'(tx_m.pop_front());
                else udf_m = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        phy_push = 1'b0;
        phy_pop  = 1'b0;
        rx_rd    = 1'b0;
        tx_wr    = 1'b0;
        flush    = 1'b0;
        check_state();
    endtask

    initial begin
        // Reset with every strobe asserted
        rst_n    = 1'b0;
        flush    = 1'b1;
        phy_push = 1'b1;
        phy_dout = 32'hFFFF_FFFF;
        phy_pop  = 1'b1;
        rx_rd    = 1'b1;
        tx_wr    = 1'b1;
        tx_data  = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        flush    = 1'b0;
        phy_push = 1'b0;
        phy_pop  = 1'b0;
        rx_rd    = 1'b0;
        tx_wr    = 1'b0;
        ovf_m    = 1'b0;
        udf_m    = 1'b0;
        check_state();

        // TX first-word-fall-through
        cycle(0, 0, 0, 0, 1, 32'h1122_3344, 0);
        cycle(0, 0, 0, 0, 1, 32'h5566_7788, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);

        // RX fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) cycle(1, 32'(i), 0, 0, 0, 0, 0);
        cycle(1, 32'hDEAD, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 1, 0, 0, 0);

        // Full RX with same-cycle push and read
        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++)
            cycle(1, 32'h100 + 32'(i), 0, 0, 0, 0, 0);
        cycle(1, 32'hA5, 0, 1, 0, 0, 0);
        while (rx_m.size() > 0) cycle(0, 0, 0, 1, 0, 0, 0);

        // Empty TX with same-cycle write and pop
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 1, 32'h5A, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);

        // Pointer wrap with occupancy held between 1 and 3
        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 40; k++) begin
            bit r;
            r = (rx_m.size() >= 2) &&
                (rx_m.size() == 3 || $urandom_range(0, 1) == 1);
            cycle(1, 32'h1000 + 32'(k), 0, r, 0, 0, 0);
        end
        while (rx_m.size() > 0) cycle(0, 0, 0, 1, 0, 0, 0);

        // Flush with both sides occupied and a push in the same cycle
        for (int i = 0; i < 5; i++)
            cycle(1, 32'h200 + 32'(i), 0, 0, (i < 3), 32'h300 + 32'(i), 0);
        cycle(1, 32'hBEEF, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_buf.md
Name: i2c_buf

Overview:
- Word buffer that sits between the I2C slave PHY and the host register interface.
- RX side: accepts the 32-bit words the PHY pushes after every 4th written byte and presents them to the host for reading.
- TX side: holds host-written words and presents them first-word-fall-through to the PHY, which pops one word at the start of each 4-byte read burst.
- The PHY's full/empty/push/pop/din/dout ports connect directly to this block.

Parameters:
- AW, 4, address width; each FIFO is 2**AW words deep (default 16).
- DW, 32, data word width; must match the PHY word width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous clear of both FIFOs and all flags; driven from the PHY register reset.
- phy_push  in  1  PHY write strobe; one word per cycle high.
- phy_dout  in  DW  word from the PHY; sampled when phy_push=1.
- phy_full  out  1  RX FIFO full; drives PHY full.
- phy_pop  in  1  PHY read strobe.
- phy_din  out  DW  TX head word; valid whenever phy_empty=0.
- phy_empty  out  1  TX FIFO empty; drives PHY empty.
- rx_rd  in  1  host read strobe.
- rx_data  out  DW  RX head word; valid whenever rx_empty=0.
- rx_empty  out  1  RX FIFO empty.
- rx_cnt  out  AW+1  RX occupancy.
- tx_wr  in  1  host write strobe.
- tx_data  in  DW  host word; sampled when tx_wr=1.
- tx_full  out  1  TX FIFO full.
- tx_cnt  out  AW+1  TX occupancy.
- rx_ovf  out  1  sticky flag: push attempted while RX full.
- tx_udf  out  1  sticky flag: pop attempted while TX empty.

Behaviour:
- Reset: rst_n=0 or flush=1 at a clk edge clears pointers and counts to 0 and clears rx_ovf and tx_udf. After reset: rx_empty=1, phy_empty=1, phy_full=0, tx_full=0, rx_cnt=0, tx_cnt=0.
- rst_n has priority over flush. flush has priority over any same-cycle push, pop, rd or wr; those strobes are discarded.
- Each FIFO is a circular buffer with AW-bit rd/wr pointers and an (AW+1)-bit count.
  - full is count==2**AW; empty is count==0. Both are decoded combinationally from the registered count.
  - Pointers wrap modulo 2**AW with no bubble.
- Write acceptance: a write is accepted only if full=0 at the edge, even if a read occurs in the same cycle. An accepted write stores the word at wr_ptr and increments wr_ptr.
- Write while full: the word is dropped, state is unchanged, and the sticky ovf flag is set (RX side only).
- Read acceptance: a read is accepted only if empty=0 at the edge. An accepted read increments rd_ptr.
- Read while empty: no state change; the sticky udf flag is set (TX side only).
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
- Head data: rx_data and phy_din are combinational reads at rd_ptr (FWFT), with zero latency from count becoming nonzero.
  - The PHY loads din in the same cycle its pop is high, so the head word must already be stable when pop asserts.
  - The next head word appears in the cycle after an accepted pop.
- Write-to-visible latency: a word written at edge N is visible on the head and empty deasserts after edge N (1 cycle).
- Count update: count=count+wr_acc-rd_acc each cycle; no other arithmetic. Width AW+1 covers 0..2**AW.
- Unused storage is never read, so memory contents need no reset.
- Sticky flags remain set until rst_n or flush.

Decomposition:
- Shared package i2c_pkg holds the I2C_DW=32 and I2C_AW=4 defaults, used by the PHY and this block.
- One sub-module, i2c_buf_fifo: a parameterised FWFT FIFO with full/empty/count, accept qualifiers and ovf/udf outputs, instantiated twice (RX and TX).

Test Plan:
- Reset with all strobes high and rst_n=0 -> after release, rx_empty=1, phy_empty=1, counts 0, flags 0.
- tx_wr 0x11223344 then 0x55667788 -> phy_empty=0 one cycle later; phy_din=0x11223344. Pop -> next cycle phy_din=0x55667788 and tx_cnt=1. Pop -> phy_empty=1.
- 16 phy_push with values 0..15 -> phy_full=1 and rx_cnt=16. 17th push of 0xDEAD -> dropped, rx_ovf=1. Read 16 -> data 0..15 in order, rx_empty=1.
- Full RX, same-cycle push 0xA5 and rx_rd -> push dropped, rx_ovf=1, rx_cnt=15. Empty TX, same-cycle tx_wr 0x5A and phy_pop -> tx_udf=1, tx_cnt=1, phy_din=0x5A.
- Wrap: 40 interleaved push/read of incrementing data with occupancy 1..3 -> read stream matches written stream exactly, no flags set.
- flush asserted with RX at 5 words, TX at 3 words, and a push in the same cycle -> next cycle both empty, counts 0, flags cleared, pushed word discarded.
